// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if: key event handshake between the keypad scanner and its consumer
// key_valid/key_code: pending event and its key number (row*4+col)
// key_ack: consumer accepts the pending event
// overrun: sticky flag, a press was dropped
interface keypad_scan_ctrl_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ack;
  logic       overrun;
  modport master (output key_valid, output key_code, output overrun, input key_ack);
  modport slave (input key_valid, input key_code, input overrun, output key_ack);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad row scanner with two-sample debounce and key event handshake
// clk/reset: rising-edge clock, asynchronous active-high reset
// enable: scanning enabled; scan_in: active-low return lines
// scan_out: one-cold row drive; row_index: driven row; key_state: debounced map, bit row*4+col
// kbus: key event handshake (master side)
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES   = 10,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [3:0]                scan_in,
  output logic [3:0]                scan_out,
  output logic [1:0]                row_index,
  output logic [15:0]               key_state,
  keypad_scan_ctrl_if.master        kbus
);
  typedef enum logic [1:0] {SETTLE, WAIT_DB, EVAL, NEXT} state_t;
  state_t       r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [1:0]   r_row;
  logic [3:0]   r_scan, r_sa, r_sb, r_code;
  logic [15:0]  r_key_state;
  logic         r_valid, r_ovr;
  logic         w_s_done, w_d_done, w_eval, w_ack, w_accept, w_ovr_set;
  logic [3:0]   w_stable, w_row_bits, w_new, w_others;
  logic [1:0]   w_col;
  always_comb begin
    w_s_done   = r_cnt == CNT_W'(SETTLE_CYCLES - 1);
    w_d_done   = r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
    w_next     = !enable ? SETTLE :
                 r_state == SETTLE  ? (w_s_done ? WAIT_DB : SETTLE) :
                 r_state == WAIT_DB ? (w_d_done ? EVAL : WAIT_DB) :
                 r_state == EVAL    ? NEXT : SETTLE;
    w_cnt_next = (enable && ((r_state == SETTLE && !w_s_done) || (r_state == WAIT_DB && !w_d_done)))
                 ? r_cnt + CNT_W'(1) : '0;
    w_stable   = ~(r_sa ^ r_sb);
    w_row_bits = r_key_state[{r_row, 2'b00} +: 4];
    w_new      = w_stable & r_sb & ~w_row_bits;
    w_col      = w_new[0] ? 2'd0 : w_new[1] ? 2'd1 : w_new[2] ? 2'd2 : 2'd3;
    w_others   = w_new & ~(4'b1 << w_col);
    w_eval     = enable && r_state == EVAL;
    w_ack      = r_valid && kbus.key_ack;
    // an ack in the EVAL cycle frees the slot for this row's candidate
    w_accept   = w_eval && |w_new && (!r_valid || kbus.key_ack);
    w_ovr_set  = w_eval && (|w_others || (|w_new && r_valid && !kbus.key_ack));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= SETTLE;
      r_cnt       <= '0;
      r_row       <= 2'd0;
      r_scan      <= 4'b1110;
      r_sa        <= 4'd0;
      r_sb        <= 4'd0;
      r_key_state <= 16'd0;
      r_valid     <= 1'b0;
      r_code      <= 4'd0;
      r_ovr       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      // NEXT drives the following row; otherwise keep (or restore after disable) the current one
      r_scan  <= !enable ? 4'b1111 : ~(4'b1 << (r_state == NEXT ? r_row + 2'd1 : r_row));
      if (enable && r_state == SETTLE && w_s_done) r_sa <= ~scan_in;
      if (enable && r_state == WAIT_DB && w_d_done) r_sb <= ~scan_in;
      if (w_eval) r_key_state[{r_row, 2'b00} +: 4] <= (w_stable & r_sb) | (~w_stable & w_row_bits);
      if (enable && r_state == NEXT) r_row <= r_row + 2'd1;
      if (w_accept) r_code <= {r_row, w_col};
      r_valid <= w_accept ? 1'b1 : w_ack ? 1'b0 : r_valid;
      r_ovr   <= w_ovr_set ? 1'b1 : w_ack ? 1'b0 : r_ovr;
    end
  end
  assign scan_out       = r_scan;
  assign row_index      = r_row;
  assign key_state      = r_key_state;
  assign kbus.key_valid = r_valid;
  assign kbus.key_code  = r_code;
  assign kbus.overrun   = r_ovr;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed self-checking bench for keypad_scan_ctrl (SETTLE=4, DEBOUNCE=8)
module tb_keypad_scan_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [3:0]  scan_in = 4'hF;
  logic [3:0]  scan_out;
  logic [1:0]  row_index;
  logic [15:0] key_state;
  int          checks = 0;
  int          failures = 0;
  keypad_scan_ctrl_if kif();
  keypad_scan_ctrl #(.SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .enable(enable), .scan_in(scan_in),
    .scan_out(scan_out), .row_index(row_index), .key_state(key_state), .kbus(kif)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one full 14-clock row: a held through sample_a, b through sample_b, optional acks on edge 1 / EVAL
  task automatic row(input logic [3:0] a, input logic [3:0] b, input logic ack0, input logic acke);
    scan_in = a; kif.key_ack = ack0; tick(1); kif.key_ack = 1'b0; tick(3);
    scan_in = b; tick(8);
    kif.key_ack = acke; tick(1); kif.key_ack = 1'b0; tick(1);
  endtask
  task automatic ev(input string tag, input logic v, input logic [3:0] c, input logic o, input logic [15:0] ks);
    chk({tag, "_valid"}, 32'(kif.key_valid), 32'(v));
    chk({tag, "_code"}, 32'(kif.key_code), 32'(c));
    chk({tag, "_ovr"}, 32'(kif.overrun), 32'(o));
    chk({tag, "_ks"}, 32'(key_state), 32'(ks));
  endtask
  initial begin
    kif.key_ack = 1'b0;
    tick(2);
    chk("rst_scan", 32'(scan_out), 32'hE);
    chk("rst_row", 32'(row_index), 32'd0);
    ev("rst", 1'b0, 4'd0, 1'b0, 16'h0000);
    reset = 1'b0;
    row(4'hF, 4'hF, 1'b0, 1'b0); chk("t1_scan1", 32'(scan_out), 32'hD); chk("t1_row1", 32'(row_index), 32'd1);
    row(4'hF, 4'hF, 1'b0, 1'b0); chk("t1_scan2", 32'(scan_out), 32'hB);
    row(4'hF, 4'hF, 1'b0, 1'b0); chk("t1_scan3", 32'(scan_out), 32'h7);
    row(4'hF, 4'hF, 1'b0, 1'b0); chk("t1_scan0", 32'(scan_out), 32'hE);
    ev("t1_idle", 1'b0, 4'd0, 1'b0, 16'h0000);
    row(4'hF, 4'hF, 1'b0, 1'b0);
    row(4'hB, 4'hB, 1'b0, 1'b0); ev("t2_key6", 1'b1, 4'd6, 1'b0, 16'h0040);
    row(4'hF, 4'hF, 1'b1, 1'b0); ev("t2_ack", 1'b0, 4'd6, 1'b0, 16'h0040);
    row(4'hF, 4'hF, 1'b0, 1'b0);
    row(4'hE, 4'hF, 1'b0, 1'b0); ev("t3_bounce_a", 1'b0, 4'd6, 1'b0, 16'h0040);
    row(4'hB, 4'hB, 1'b0, 1'b0); ev("t2_hold", 1'b0, 4'd6, 1'b0, 16'h0040);
    row(4'hF, 4'hF, 1'b0, 1'b0);
    row(4'hF, 4'hF, 1'b0, 1'b0);
    row(4'hF, 4'hE, 1'b0, 1'b0); ev("t3_bounce_b", 1'b0, 4'd6, 1'b0, 16'h0040);
    row(4'hF, 4'hF, 1'b0, 1'b0); ev("t3_release", 1'b0, 4'd6, 1'b0, 16'h0000);
    row(4'hF, 4'hF, 1'b0, 1'b0);
    row(4'hF, 4'hF, 1'b0, 1'b0);
    row(4'hF, 4'hF, 1'b0, 1'b0);
    row(4'hB, 4'hB, 1'b0, 1'b0); ev("t4_key6", 1'b1, 4'd6, 1'b0, 16'h0040);
    row(4'hD, 4'hD, 1'b0, 1'b0); ev("t4_drop9", 1'b1, 4'd6, 1'b1, 16'h0240);
    row(4'hF, 4'hF, 1'b1, 1'b0); ev("t4_ack", 1'b0, 4'd6, 1'b0, 16'h0240);
    row(4'hF, 4'hF, 1'b0, 1'b0);
    row(4'h6, 4'h6, 1'b0, 1'b0); ev("t5_multi", 1'b1, 4'd4, 1'b1, 16'h0290);
    row(4'hD, 4'hD, 1'b0, 1'b0); ev("t5_hold9", 1'b1, 4'd4, 1'b1, 16'h0290);
    row(4'hF, 4'hF, 1'b1, 1'b0); ev("t5_ack", 1'b0, 4'd4, 1'b0, 16'h0290);
    row(4'hE, 4'hE, 1'b0, 1'b0); ev("t5_key0", 1'b1, 4'd0, 1'b0, 16'h0291);
    row(4'h6, 4'h6, 1'b0, 1'b0);
    row(4'hE, 4'hE, 1'b0, 1'b1); ev("t5_ack_eval", 1'b1, 4'd8, 1'b0, 16'h0191);
    row(4'hC, 4'hC, 1'b0, 1'b1); ev("t5_set_wins", 1'b1, 4'd12, 1'b1, 16'h3191);
    row(4'hF, 4'hF, 1'b0, 1'b0); chk("t6_pre_scan", 32'(scan_out), 32'hD);
    scan_in = 4'hF; tick(6);
    reset = 1'b1; #1;
    chk("t6_rst_scan", 32'(scan_out), 32'hE);
    chk("t6_rst_row", 32'(row_index), 32'd0);
    ev("t6_rst", 1'b0, 4'd0, 1'b0, 16'h0000);
    reset = 1'b0;
    row(4'hF, 4'hF, 1'b0, 1'b0); chk("t6_row1", 32'(scan_out), 32'hD);
    tick(2); enable = 1'b0; tick(1);
    chk("t6_dis_scan", 32'(scan_out), 32'hF); chk("t6_dis_row", 32'(row_index), 32'd1);
    tick(5);
    chk("t6_dis_scan2", 32'(scan_out), 32'hF); chk("t6_dis_row2", 32'(row_index), 32'd1);
    enable = 1'b1; tick(1);
    chk("t6_en_scan", 32'(scan_out), 32'hD);
    tick(2); scan_in = 4'hD; tick(9);
    chk("t6_pre_eval", 32'(kif.key_valid), 32'd0);
    tick(1);
    ev("t6_key5", 1'b1, 4'd5, 1'b0, 16'h0020);
    tick(1);
    chk("t6_next_scan", 32'(scan_out), 32'hB); chk("t6_next_row", 32'(row_index), 32'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
